// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: adder width limit and per-bit adder result type.
package alu_pkg;

  localparam int unsigned FA_MAX_WIDTH = 64;

  typedef struct packed {
    logic carry;
    logic sum;
  } fa_bit_t;

endpackage : alu_pkg

// File: rtl/full_adder_cell.sv
// Purely combinational 1-bit full adder cell, the ripple element of full_adder_reg.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_cell

// File: rtl/full_adder_reg.sv
// Registered ripple-carry adder: {carry,sum} = a + b + c, one cycle of latency
// behind a single valid stage. WIDTH=1 degenerates to a plain registered full adder.
module full_adder_reg
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_width_check
    $error("full_adder_reg: WIDTH %0d outside 1..%0d", WIDTH, FA_MAX_WIDTH);
  end

  logic [WIDTH-1:0] sum_next;
  logic             carry_next;

  // Each stage owns its carry net so the chain is not one self-referencing vector.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic    cin;
    fa_bit_t res;

    if (i == 0) begin : g_first
      assign cin = c;
    end else begin : g_rest
      assign cin = g_bit[i-1].res.carry;
    end

    full_adder_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (cin),
      .s    (res.sum),
      .cout (res.carry)
    );

    assign sum_next[i] = res.sum;
  end

  assign carry_next = g_bit[WIDTH-1].res.carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      carry     <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_next;
        carry <= carry_next;
      end
    end
  end

endmodule : full_adder_reg

// File: tb/tb_full_adder_reg.sv
// Directed bench for full_adder_reg at WIDTH 1, 4 and 8 with hand-computed expectations.
module tb_full_adder_reg;

  logic       clk = 1'b0;
  logic       rst;

  logic       v1, a1, b1, c1, ov1, s1, co1;
  logic       v4, c4, ov4, co4;
  logic [3:0] a4, b4, s4;
  logic       v8, c8, ov8, co8;
  logic [7:0] a8, b8, s8;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  full_adder_reg #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .c(c1),
    .out_valid(ov1), .sum(s1), .carry(co1)
  );

  full_adder_reg #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .c(c4),
    .out_valid(ov4), .sum(s4), .carry(co4)
  );

  full_adder_reg #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .c(c8),
    .out_valid(ov8), .sum(s8), .carry(co8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  initial begin
    logic [7:0] tbl_sum;
    logic [7:0] tbl_carry;
    logic [2:0] abc;
    logic [8:0] exp8;
    logic       expv8;

    tbl_sum   = 8'b1001_0110;
    tbl_carry = 8'b1110_1000;

    rst = 1'b1;
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    v4 = 1'b0; a4 = '0;   b4 = '0;   c4 = 1'b0;
    v8 = 1'b0; a8 = '0;   b8 = '0;   c8 = 1'b0;

    // Reset state of every instance
    step();
    chk("rst_w1", {ov1, co1, s1}, 10'b000);
    chk("rst_w4", {ov4, co4, s4}, 10'h0);
    chk("rst_w8", {ov8, co8, s8}, 10'h0);
    rst = 1'b0;

    // WIDTH=1 exhaustive, back-to-back
    for (int k = 0; k < 8; k++) begin
      abc = 3'(k);
      {a1, b1, c1} = abc;
      v1 = 1'b1;
      step();
      chk($sformatf("w1_abc%0d%0d%0d", abc[2], abc[1], abc[0]),
          {ov1, co1, s1}, {7'b0, 1'b1, tbl_carry[k], tbl_sum[k]});
    end

    // Reset held for two cycles with valid inputs present
    rst = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1 = 1'b1;
    step();
    chk("rst_hold1", {ov1, co1, s1}, 10'b000);
    step();
    chk("rst_hold2", {ov1, co1, s1}, 10'b000);
    rst = 1'b0;
    step();
    chk("rst_release", {ov1, co1, s1}, 10'b111);

    // Hold when in_valid drops
    a1 = 1'b1; b1 = 1'b0; c1 = 1'b0; v1 = 1'b1;
    step();
    chk("hold_load", {ov1, co1, s1}, 10'b101);
    v1 = 1'b0; a1 = 1'b0; b1 = 1'b1; c1 = 1'b1;
    step();
    chk("hold_1", {ov1, co1, s1}, 10'b001);
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    step();
    chk("hold_2", {ov1, co1, s1}, 10'b001);

    // Input accepted on the same edge as reset is discarded
    v1 = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0; rst = 1'b1;
    step();
    chk("midrst_a", {ov1, co1, s1}, 10'b000);
    rst = 1'b0; v1 = 1'b0;
    step();
    chk("midrst_b", {ov1, co1, s1}, 10'b000);

    // WIDTH=4 carry ripple, back-to-back
    v4 = 1'b1; a4 = 4'hF; b4 = 4'h1; c4 = 1'b0;
    step();
    chk("w4_f_1_0", {ov4, co4, s4}, {4'b0, 1'b1, 1'b1, 4'h0});
    a4 = 4'h7; b4 = 4'h8; c4 = 1'b1;
    step();
    chk("w4_7_8_1", {ov4, co4, s4}, {4'b0, 1'b1, 1'b1, 4'h0});
    a4 = 4'h5; b4 = 4'h2; c4 = 1'b1;
    step();
    chk("w4_5_2_1", {ov4, co4, s4}, {4'b0, 1'b1, 1'b0, 4'h8});
    v4 = 1'b0;
    step();
    chk("w4_hold", {ov4, co4, s4}, {4'b0, 1'b0, 1'b0, 4'h8});

    // WIDTH=8 random traffic against a reference sum
    exp8  = '0;
    expv8 = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      v8 = 1'($urandom_range(0, 3) != 0);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      c8 = 1'($urandom);
      step();
      expv8 = v8;
      if (v8) exp8 = {1'b0, a8} + {1'b0, b8} + 9'(c8);
      chk($sformatf("w8_rand%0d", n), {ov8, co8, s8}, {expv8, exp8});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_full_adder_reg

// File: doc/full_adder_reg.md
Name: full_adder_reg

Overview:
Registered full adder for the ALU datapath.
- Adds operands a and b plus a carry-in c, and registers the sum and carry-out.
- Data flows through a single-cycle valid pipeline stage.
- With the default WIDTH of 1 it is exactly a 1-bit full adder (a, b, c -> sum, carry) with one cycle of latency. Wider builds form a ripple-carry adder.

Parameters:
- WIDTH, 1, operand and sum width in bits; legal range 1..64.

Ports:
- clk        input   1      rising-edge clock
- rst        input   1      synchronous reset, active-high
- in_valid   input   1      a/b/c are valid this cycle
- a          input   WIDTH  operand A
- b          input   WIDTH  operand B
- c          input   1      carry-in
- out_valid  output  1      sum/carry hold a fresh result
- sum        output  WIDTH  registered sum, {carry,sum} = a + b + c
- carry      output  1      registered carry-out (MSB of full result)

Behaviour:
- Combinational core: bit i computes s_i = a[i] ^ b[i] ^ c_i and c_{i+1} = (a[i]&b[i]) | (a[i]&c_i) | (b[i]&c_i), with c_0 = c. Carry-out = c_WIDTH.
- Arithmetic is unsigned. Result {carry,sum} is WIDTH+1 bits and never truncated; no overflow flag.
- Latency is exactly 1 clock: inputs sampled at edge N appear on sum/carry after edge N.
- On a clk edge with rst=1:
  - out_valid, sum and carry all go to 0.
  - Inputs that edge are ignored, even if in_valid=1.
- On a clk edge with rst=0 and in_valid=1:
  - sum and carry load the core result.
  - out_valid <= 1.
- On a clk edge with rst=0 and in_valid=0:
  - sum and carry hold their previous values.
  - out_valid <= 0.
- Back-to-back in_valid=1 on every cycle: one result per cycle, no bubbles. There is no backpressure (no ready).
- Reset mid-stream: the in-flight result is discarded. First valid output comes 1 cycle after the first accepted input following rst deassertion.
- No combinational path from inputs to outputs; all outputs come straight from flops.
- Outputs are 0 out of reset until the first accepted transaction.

Decomposition:
- Shared package alu_pkg holds:
  - localparam FA_MAX_WIDTH = 64
  - typedef struct packed {logic carry; logic sum;} fa_bit_t, for per-bit results.
- One sub-module: full_adder_cell, a purely combinational 1-bit cell (a, b, cin -> s, cout).
  - Instantiated WIDTH times in a generate loop, chained ripple-carry.
  - full_adder_reg adds the valid/output register stage around it.

Test Plan:
- WIDTH=1 exhaustive: apply all 8 (a,b,c) combos with in_valid=1 on consecutive cycles. Required results after 1 cycle each:
  - 000 -> sum0 carry0
  - 001 -> 1,0
  - 010 -> 1,0
  - 011 -> 0,1
  - 100 -> 1,0
  - 101 -> 0,1
  - 110 -> 0,1
  - 111 -> 1,1
  - out_valid stays high throughout.
- Reset: drive a=1,b=1,c=1, in_valid=1 with rst=1 for 2 cycles. Required: sum=0, carry=0, out_valid=0. After rst=0, one cycle later: sum=1, carry=1, out_valid=1.
- Hold: after a=1,b=0,c=0 (sum=1), drop in_valid and toggle a/b/c. Required: sum=1, carry=0 held; out_valid=0 from the next cycle.
- Reset mid-stream: in_valid=1 with a=1,b=1,c=0, assert rst on the following edge. Required: outputs 0 and no out_valid pulse for the discarded input.
- WIDTH=4 carry ripple:
  - a=4'hF, b=4'h1, c=0 -> sum=4'h0, carry=1.
  - a=4'h7, b=4'h8, c=1 -> sum=4'h0, carry=1.
  - a=4'h5, b=4'h2, c=1 -> sum=4'h8, carry=0.
  - Each result appears 1 cycle after its input.
- Random: 1000 random in_valid/a/b/c cycles at WIDTH=8. Scoreboard checks {carry,sum} == a+b+c delayed by 1 cycle whenever out_valid=1, and that outputs hold when in_valid=0.
